// File: rtl/axi_lite_led_responder_if.sv
// ---------------------------------------------------------------------------
// axi_lite_led_responder_if
// AXI4-Lite bus bundle between the JTAG-to-AXI initiator (master) and the
// board I/O responder (slave).
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel
//   bresp/bvalid/bready         write response channel
//   araddr/arvalid/arready      read address channel
//   rdata/rresp/rvalid/rready   read data channel
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where valid and ready are both 1; once valid is raised, the payload stays
// stable and valid stays high until that edge.
// ---------------------------------------------------------------------------
interface axi_lite_led_responder_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_led_responder.sv
// ---------------------------------------------------------------------------
// axi_lite_led_responder
// AXI4-Lite slave giving the JTAG-to-AXI initiator register access to board
// I/O: RGB LED drive, synchronised buttons/switches, a scratch word and a
// free-running cycle counter.
// Ports:
//   clk_sys  system clock, all logic on the rising edge
//   reset    synchronous active-high reset
//   s        AXI4-Lite slave bus (see axi_lite_led_responder_if)
//   btn_i    raw push buttons BTN3..BTN0 (asynchronous)
//   sw_i     raw DIP switches SW3..SW0 (asynchronous)
//   led_o    [11:0] {LD3..LD0} x {B,G,R}; [15:12] LD7..LD4
// Register map (byte offsets):
//   0x00 ID (RO), 0x04 LED (RW, 16 bits), 0x08 INPUT (RO),
//   0x0C SCRATCH (RW), 0x10 CYCLES (RO), 0x14..0x1C unmapped -> SLVERR
// ---------------------------------------------------------------------------
module axi_lite_led_responder #(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] ID_VALUE   = 32'h4A44_5231
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    axi_lite_led_responder_if.slave  s,
    input  logic [3:0]               btn_i,
    input  logic [3:0]               sw_i,
    output logic [15:0]              led_o
);
    localparam int IW = ADDR_WIDTH - 2;

    localparam logic [IW-1:0] IDX_ID      = IW'(0);
    localparam logic [IW-1:0] IDX_LED     = IW'(1);
    localparam logic [IW-1:0] IDX_INPUT   = IW'(2);
    localparam logic [IW-1:0] IDX_SCRATCH = IW'(3);
    localparam logic [IW-1:0] IDX_CYCLES  = IW'(4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel holding registers
    logic          aw_held;
    logic [IW-1:0] aw_idx;
    logic          w_held;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;

    // Read channel output registers
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic [1:0]    rresp_q;

    // Register file
    logic [15:0]   led_reg;
    logic [31:0]   scratch;
    logic [31:0]   cycles;

    // Two-flop input synchronisers
    logic [3:0]    btn_meta, btn_sync;
    logic [3:0]    sw_meta, sw_sync;

    logic          aw_fire, w_fire, ar_fire, commit;
    logic          wr_led, wr_scratch;
    logic [1:0]    wr_resp;
    logic [31:0]   rd_data;
    logic [1:0]    rd_resp;
    logic [IW-1:0] ar_idx;

    // Byte-offset bits are ignored; this keeps them visibly consumed.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{s.awaddr[1:0], s.araddr[1:0]};

    // Ready/valid outputs. Both write channels stall while a response is
    // outstanding so at most one write is ever in flight.
    assign s.awready = ~aw_held & ~bvalid_q;
    assign s.wready  = ~w_held  & ~bvalid_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = ~rvalid_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;
    assign led_o     = led_reg;

    assign aw_fire = s.awvalid & s.awready;
    assign w_fire  = s.wvalid  & s.wready;
    assign ar_fire = s.arvalid & s.arready;
    // Commit in the first cycle both halves of the write are held.
    assign commit  = aw_held & w_held;
    assign ar_idx  = s.araddr[ADDR_WIDTH-1:2];

    // Write address decode
    always_comb begin
        wr_resp    = RESP_OKAY;
        wr_led     = 1'b0;
        wr_scratch = 1'b0;
        case (aw_idx)
            IDX_ID, IDX_INPUT, IDX_CYCLES: wr_resp = RESP_OKAY; // read-only: dropped silently
            IDX_LED:                       wr_led = 1'b1;
            IDX_SCRATCH:                   wr_scratch = 1'b1;
            default:                       wr_resp = RESP_SLVERR;
        endcase
    end

    // Read data mux; sampled from current register values, so a read that
    // coincides with a commit to the same register sees the pre-write value.
    always_comb begin
        rd_data = 32'h0;
        rd_resp = RESP_OKAY;
        case (ar_idx)
            IDX_ID:      rd_data = ID_VALUE;
            IDX_LED:     rd_data = {16'h0, led_reg};
            IDX_INPUT:   rd_data = {24'h0, sw_sync, btn_sync};
            IDX_SCRATCH: rd_data = scratch;
            IDX_CYCLES:  rd_data = cycles;
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    // Write channel control
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            aw_held  <= 1'b0;
            aw_idx   <= '0;
            w_held   <= 1'b0;
            w_data_q <= 32'h0;
            w_strb_q <= 4'h0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_idx  <= s.awaddr[ADDR_WIDTH-1:2];
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= s.wdata;
                w_strb_q <= s.wstrb;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bvalid_q && s.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Register file updates and cycle counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            led_reg <= 16'h0;
            scratch <= 32'h0;
            cycles  <= 32'h0;
        end else begin
            cycles <= cycles + 32'd1;
            if (commit && wr_led) begin
                if (w_strb_q[0]) led_reg[7:0]  <= w_data_q[7:0];
                if (w_strb_q[1]) led_reg[15:8] <= w_data_q[15:8];
            end
            if (commit && wr_scratch) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_strb_q[i]) scratch[8*i +: 8] <= w_data_q[8*i +: 8];
                end
            end
        end
    end

    // Read channel
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
        end else if (rvalid_q && s.rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // Input synchronisers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_meta <= 4'h0;
            btn_sync <= 4'h0;
            sw_meta  <= 4'h0;
            sw_sync  <= 4'h0;
        end else begin
            btn_meta <= btn_i;
            btn_sync <= btn_meta;
            sw_meta  <= sw_i;
            sw_sync  <= sw_meta;
        end
    end
endmodule

// File: tb/tb_axi_lite_led_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_led_responder
// Directed bench for axi_lite_led_responder. Inputs change on the falling
// edge and outputs are sampled on the falling edge; every task starts and
// ends on a falling edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_led_responder;
    localparam int          TIMEOUT = 50;
    localparam logic [31:0] ID_EXP  = 32'h4A44_5231;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  btn_i   = 4'h0;
    logic [3:0]  sw_i    = 4'h0;
    logic [15:0] led_o;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;

    axi_lite_led_responder_if #(.ADDR_WIDTH(5)) bus ();

    axi_lite_led_responder #(.ADDR_WIDTH(5), .ID_VALUE(ID_EXP)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .s       (bus),
        .btn_i   (btn_i),
        .sw_i    (sw_i),
        .led_o   (led_o)
    );

    // Clock
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int t;
        bus.bready = 1'b1;
        t = 0;
        while (!bus.bvalid && t < TIMEOUT) begin
            @(negedge clk_sys);
            t++;
        end
        check("b_timeout", 32'(!bus.bvalid), 32'h0);
        resp = bus.bresp;
        @(negedge clk_sys);
        bus.bready = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_pend, w_pend, aw_go, w_go;
        int t;
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        t = 0;
        while ((aw_pend || w_pend) && t < TIMEOUT) begin
            aw_go = aw_pend && bus.awready;
            w_go  = w_pend && bus.wready;
            @(negedge clk_sys);
            t++;
            if (aw_go) begin aw_pend = 1'b0; bus.awvalid = 1'b0; end
            if (w_go)  begin w_pend  = 1'b0; bus.wvalid  = 1'b0; end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("aw_w_timeout", 32'(aw_pend || w_pend), 32'h0);
        wait_b(resp);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int t;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < TIMEOUT) begin
            @(negedge clk_sys);
            t++;
        end
        check("ar_timeout", 32'(!bus.arready), 32'h0);
        @(negedge clk_sys);
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        t = 0;
        while (!bus.rvalid && t < TIMEOUT) begin
            @(negedge clk_sys);
            t++;
        end
        check("r_timeout", 32'(!bus.rvalid), 32'h0);
        data = bus.rdata;
        resp = bus.rresp;
        @(negedge clk_sys);
        bus.rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] c1, c2;
        logic [1:0]  rsp;

        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        @(negedge clk_sys);
        do_reset(3);

        // 1: reset state, ID and LED reads
        check("rst_valids", 32'({bus.bvalid, bus.rvalid}), 32'h0);
        check("rst_readys", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
        check("rst_resp_data", {bus.rdata[29:0], bus.bresp}, 32'h0);
        check("rst_rresp", 32'(bus.rresp), 32'h0);
        check("rst_led", 32'(led_o), 32'h0);
        axi_read(5'h00, rd, rsp);
        check("id_data", rd, ID_EXP);
        check("id_resp", 32'(rsp), 32'h0);
        axi_read(5'h04, rd, rsp);
        check("led_rst_read", rd, 32'h0);

        // 2: LED write, full and partial strobes
        axi_write(5'h04, 32'h0000_F00F, 4'hF, rsp);
        check("led_bresp", 32'(rsp), 32'h0);
        check("led_pins", 32'(led_o), 32'h0000_F00F);
        axi_read(5'h04, rd, rsp);
        check("led_readback", rd, 32'h0000_F00F);
        axi_write(5'h04, 32'hFFFF_AB00, 4'b0010, rsp);
        check("led_partial_pins", 32'(led_o), 32'h0000_AB0F);
        axi_read(5'h04, rd, rsp);
        check("led_upper_zero", rd, 32'h0000_AB0F);

        // 3: SCRATCH byte strobes
        axi_write(5'h0C, 32'hDEAD_BEEF, 4'hF, rsp);
        axi_write(5'h0C, 32'h1234_5678, 4'b0101, rsp);
        check("scr_bresp", 32'(rsp), 32'h0);
        axi_read(5'h0C, rd, rsp);
        check("scr_strb", rd, 32'hDE34_BE78);

        // 4: W three cycles ahead of AW, response back-pressured
        bus.wdata  = 32'hCAFE_F00D;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        check("t4_wready_pre", 32'(bus.wready), 32'h1);
        @(negedge clk_sys);
        bus.wvalid = 1'b0;
        check("t4_w_held", 32'({bus.awready, bus.wready}), 32'h2);
        repeat (2) @(negedge clk_sys);
        bus.awaddr  = 5'h0C;
        bus.awvalid = 1'b1;
        bus.bready  = 1'b0;
        check("t4_awready_pre", 32'(bus.awready), 32'h1);
        @(negedge clk_sys);
        bus.awvalid = 1'b0;
        check("t4_both_held", 32'({bus.awready, bus.wready, bus.bvalid}), 32'h0);
        @(negedge clk_sys);
        for (int i = 0; i < 5; i++) begin
            check("t4_b_hold", 32'({bus.bvalid, bus.bresp, bus.awready, bus.wready}), 32'h10);
            @(negedge clk_sys);
        end
        bus.bready = 1'b1;
        @(negedge clk_sys);
        bus.bready = 1'b0;
        check("t4_b_done", 32'({bus.bvalid, bus.awready, bus.wready}), 32'h3);
        axi_read(5'h0C, rd, rsp);
        check("t4_scr", rd, 32'hCAFE_F00D);

        // 5: unmapped and read-only accesses
        axi_read(5'h18, rd, rsp);
        check("unmap_rdata", rd, 32'h0);
        check("unmap_rresp", 32'(rsp), 32'h2);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, rsp);
        check("unmap_bresp", 32'(rsp), 32'h2);
        axi_write(5'h00, 32'h0000_0000, 4'hF, rsp);
        check("ro_bresp", 32'(rsp), 32'h0);
        axi_read(5'h00, rd, rsp);
        check("ro_id_kept", rd, ID_EXP);
        axi_read(5'h04, rd, rsp);
        check("unmap_led_kept", rd, 32'h0000_AB0F);
        axi_read(5'h0C, rd, rsp);
        check("unmap_scr_kept", rd, 32'hCAFE_F00D);

        // 6: input synchroniser latency and cycle counter
        btn_i = 4'hA;
        sw_i  = 4'h5;
        axi_read(5'h08, rd, rsp);
        check("input_too_early", rd, 32'h0);
        axi_read(5'h08, rd, rsp);
        check("input_synced", rd, 32'h0000_005A);
        axi_read(5'h10, c1, rsp);
        repeat (8) @(negedge clk_sys);
        axi_read(5'h10, c2, rsp);
        check("cycles_delta", c2 - c1, 32'd10);

        // 7: reset with AW held and W pending
        bus.awaddr  = 5'h04;
        bus.awvalid = 1'b1;
        @(negedge clk_sys);
        bus.awvalid = 1'b0;
        bus.wdata   = 32'h0000_1234;
        bus.wstrb   = 4'hF;
        bus.wvalid  = 1'b1;
        reset       = 1'b1;
        repeat (2) @(negedge clk_sys);
        bus.wvalid  = 1'b0;
        reset       = 1'b0;
        axi_read(5'h10, rd, rsp);
        check("rst7_cycles", rd, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("rst7_no_b", 32'(bus.bvalid), 32'h0);
            @(negedge clk_sys);
        end
        check("rst7_led", 32'(led_o), 32'h0);
        check("rst7_readys", 32'({bus.awready, bus.wready}), 32'h3);
        axi_read(5'h0C, rd, rsp);
        check("rst7_scr", rd, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
